// File: rtl/sticker_sampler.sv
`default_nettype none
// ============================================================================
// Module   : sticker_sampler
// Purpose  : Samples the average colour of a 3x3 grid of cube stickers from
//            one full video frame and streams the nine results out over a
//            valid/ready handshake. Also draws a 5x5 marker at each sticker
//            centre for the VGA overlay.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   iCLK        in   pixel clock, rising edge
//   iRST_N      in   asynchronous active-low reset
//   iVS_N       in   vertical sync (active low); frame boundary = falling edge
//   iRequest    in   pixel at iX/iY is active, iR/iG/iB valid
//   iX, iY      in   [9:0] H/V counter coordinates
//   iR, iG, iB  in   [9:0] pixel colour
//   iCapture    in   one-cycle request to sample the next full frame
//   oDot        out  marker overlay (combinational on iX/iY)
//   oBusy       out  high whenever the sampler is not idle
//   oStk_Valid  out  a sticker result is presented
//   iStk_Ready  in   consumer accepts the presented result
//   oStk_Idx    out  [3:0] sticker index 0..8, row-major
//   oStk_R/G/B  out  [9:0] averaged sticker colour
// ============================================================================
module sticker_sampler #(
  parameter int GRID_X0 = 264,
  parameter int GRID_Y0 = 154,
  parameter int PITCH   = 120
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iVS_N,
  input  logic       iRequest,
  input  logic [9:0] iX,
  input  logic [9:0] iY,
  input  logic [9:0] iR,
  input  logic [9:0] iG,
  input  logic [9:0] iB,
  input  logic       iCapture,
  output logic       oDot,
  output logic       oBusy,
  output logic       oStk_Valid,
  input  logic       iStk_Ready,
  output logic [3:0] oStk_Idx,
  output logic [9:0] oStk_R,
  output logic [9:0] oStk_G,
  output logic [9:0] oStk_B
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACCUM  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam logic [3:0] c_LAST_IDX = 4'd8;

  state_t      r_state;
  logic        r_vs_d;
  logic        r_busy;
  logic        r_valid;
  logic [3:0]  r_idx;
  logic [9:0]  r_col_r;
  logic [9:0]  r_col_g;
  logic [9:0]  r_col_b;

  logic [15:0] r_acc_r [9];
  logic [15:0] r_acc_g [9];
  logic [15:0] r_acc_b [9];

  logic [11:0] w_x;
  logic [11:0] w_y;
  logic [8:0]  w_in_win;
  logic [8:0]  w_dot;
  logic        w_vs_fall;
  logic        w_clear;
  logic        w_accum;
  logic [3:0]  w_sel_idx;
  logic [9:0]  w_sel_r;
  logic [9:0]  w_sel_g;
  logic [9:0]  w_sel_b;

  // Widen coordinates so the +4 / +3 window arithmetic cannot wrap.
  assign w_x = {2'b00, iX};
  assign w_y = {2'b00, iY};

  assign w_vs_fall = r_vs_d & ~iVS_N;
  assign w_clear   = (r_state == S_ARMED) && w_vs_fall;
  assign w_accum   = (r_state == S_ACCUM) && iRequest;

  // Per-sticker window (8x8, centre at offset +4) and marker (5x5) decode.
  for (genvar k = 0; k < 9; k++) begin : g_stk
    localparam logic [11:0] c_CX = 12'(GRID_X0 + (k % 3) * PITCH);
    localparam logic [11:0] c_CY = 12'(GRID_Y0 + (k / 3) * PITCH);

    assign w_in_win[k] = (w_x + 12'd4 >= c_CX) && (w_x <= c_CX + 12'd3) &&
                         (w_y + 12'd4 >= c_CY) && (w_y <= c_CY + 12'd3);
    assign w_dot[k]    = (w_x + 12'd2 >= c_CX) && (w_x <= c_CX + 12'd2) &&
                         (w_y + 12'd2 >= c_CY) && (w_y <= c_CY + 12'd2);
  end

  assign oDot = |w_dot;

  // 64 pixels of at most 1023 fit in 16 bits, so plain adds never overflow.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int k = 0; k < 9; k++) begin
        r_acc_r[k] <= '0;
        r_acc_g[k] <= '0;
        r_acc_b[k] <= '0;
      end
    end else if (w_clear) begin
      for (int k = 0; k < 9; k++) begin
        r_acc_r[k] <= '0;
        r_acc_g[k] <= '0;
        r_acc_b[k] <= '0;
      end
    end else if (w_accum) begin
      for (int k = 0; k < 9; k++) begin
        if (w_in_win[k]) begin
          r_acc_r[k] <= r_acc_r[k] + {6'd0, iR};
          r_acc_g[k] <= r_acc_g[k] + {6'd0, iG};
          r_acc_b[k] <= r_acc_b[k] + {6'd0, iB};
        end
      end
    end
  end

  // Sticker whose colour is loaded into the output registers: the current
  // index when first presenting, the next one when a transfer advances.
  assign w_sel_idx = (r_valid && (r_idx != c_LAST_IDX)) ? r_idx + 4'd1 : r_idx;
  assign w_sel_r   = r_acc_r[w_sel_idx][15:6];
  assign w_sel_g   = r_acc_g[w_sel_idx][15:6];
  assign w_sel_b   = r_acc_b[w_sel_idx][15:6];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_vs_d  <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_col_r <= '0;
      r_col_g <= '0;
      r_col_b <= '0;
    end else begin
      r_vs_d <= iVS_N;
      case (r_state)
        S_IDLE: begin
          // A coincident vsync edge only arms; the edge is not counted.
          if (iCapture) begin
            r_state <= S_ARMED;
            r_busy  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (w_vs_fall) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_vs_fall) begin
            r_state <= S_OUTPUT;
            r_idx   <= '0;
            r_valid <= 1'b0;
          end
        end
        S_OUTPUT: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_col_r <= w_sel_r;
            r_col_g <= w_sel_g;
            r_col_b <= w_sel_b;
          end else if (iStk_Ready) begin
            if (r_idx == c_LAST_IDX) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
            end else begin
              r_idx   <= w_sel_idx;
              r_col_r <= w_sel_r;
              r_col_g <= w_sel_g;
              r_col_b <= w_sel_b;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy      = r_busy;
  assign oStk_Valid = r_valid;
  assign oStk_Idx   = r_idx;
  assign oStk_R     = r_col_r;
  assign oStk_G     = r_col_g;
  assign oStk_B     = r_col_b;

endmodule
`default_nettype wire

// File: doc/sticker_sampler.md
STICKER_SAMPLER -- requirements
Module: sticker_sampler

Interface
REQ-001 SHALL have parameter GRID_X0, default 264, meaning the H counter value of the column-0 sticker centre.
REQ-002 SHALL have parameter GRID_Y0, default 154, meaning the V counter value of the row-0 sticker centre.
REQ-003 SHALL have parameter PITCH, default 120, meaning the centre-to-centre spacing in pixels, applied on both axes.
REQ-004 SHALL have port iCLK, input, 1 bit: the pixel clock; all logic is on the rising edge.
REQ-005 SHALL have port iRST_N, input, 1 bit: reset, asynchronous, active-low; clock iCLK.
REQ-006 SHALL have port iVS_N, input, 1 bit: vertical sync, active-low; a frame boundary is its falling edge.
REQ-007 SHALL have port iRequest, input, 1 bit: the pixel at iX/iY is active and iR/iG/iB are valid.
REQ-008 SHALL have ports iX and iY, input, 10 bits each: the current H/V counter coordinates.
REQ-009 SHALL have ports iR, iG and iB, input, 10 bits each: the pixel colour.
REQ-010 SHALL have port iCapture, input, 1 bit: a single-cycle request to sample the next full frame.
REQ-011 SHALL have port oDot, output, 1 bit: marker overlay, driven to the VGA stage's isDot.
REQ-012 SHALL have port oBusy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port oStk_Valid, output, 1 bit: a sticker result is present.
REQ-014 SHALL have port iStk_Ready, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port oStk_Idx, output, 4 bits: sticker index 0..8, row-major.
REQ-016 SHALL have ports oStk_R, oStk_G and oStk_B, output, 10 bits each: the averaged sticker colour.

Function
REQ-017 Sticker k (row r=k/3, col c=k%3) SHALL have centre cx=GRID_X0+c*PITCH, cy=GRID_Y0+r*PITCH.
REQ-018 oDot SHALL be combinational and high when, for any k, |iX-cx|<=2 and |iY-cy|<=2; it is independent of state and iRequest.
REQ-019 The window of sticker k SHALL be iX in [cx-4, cx+3] and iY in [cy-4, cy+3], which is 64 pixels.
REQ-020 The FSM SHALL have exactly these states: IDLE, ARMED, ACCUM, OUTPUT.
REQ-021 IDLE -> ARMED on iCapture=1; iCapture SHALL be ignored in every other state.
REQ-022 ARMED -> ACCUM on an iVS_N falling edge, detected from a registered copy of iVS_N; all 27 accumulators SHALL clear on that transition.
REQ-023 In ACCUM, each cycle with iRequest=1 and the pixel inside window k SHALL add iR, iG and iB into sticker k's R, G and B accumulators; windows do not overlap.
REQ-024 Accumulators SHALL be 16 bits unsigned; the maximum is 64*1023=65472, so overflow is impossible and no saturation is required.
REQ-025 ACCUM -> OUTPUT on the next iVS_N falling edge; the output index SHALL reset to 0.
REQ-026 In OUTPUT, oStk_Valid SHALL be high, and oStk_Idx and the colours SHALL be registered and show sticker idx, colour = accumulator[15:6].
REQ-027 The transfer SHALL occur on a cycle where oStk_Valid=1 and iStk_Ready=1; the index advances the next cycle.
REQ-028 oStk_Idx and the colour outputs SHALL be stable while oStk_Valid=1 and iStk_Ready=0.
REQ-029 The transfer of index 8 SHALL move the FSM to IDLE; oStk_Valid SHALL be 0 in the following cycle.
REQ-030 oStk_Valid SHALL rise one cycle after entering OUTPUT, so the first result appears 1 cycle after the closing vsync edge.
REQ-031 iVS_N edges during OUTPUT SHALL be ignored; accumulators are not modified until the next ARMED -> ACCUM transition.
REQ-032 Fixed latency from iCapture to the first result: between 1 and 2 frames plus 2 cycles.
REQ-033 A vsync edge and iCapture in the same cycle while in IDLE SHALL only arm; the edge is not counted.

Reset
REQ-034 When iRST_N=0, the FSM SHALL go to IDLE, with oBusy=0, oStk_Valid=0, oStk_Idx=0, colour outputs 0, accumulators 0, and the vsync history register 1.
REQ-035 Reset asserted mid-ACCUM or mid-OUTPUT SHALL discard all partial results; no result is emitted after release without a new iCapture.
REQ-036 oDot SHALL remain purely a function of iX and iY during reset.

Verification
REQ-037 Uniform frame test: stimulus is iR=1023, iG=0, iB=512 on every pixel, iCapture, 2 frames. Required response: 9 results, idx 0..8 in order, each R=1023, G=0, B=512.
REQ-038 Single-window test: stimulus is iR=640 only inside window 4 (cx=384, cy=274) and 0 elsewhere. Required response: idx4 R=640; all other results R=0.
REQ-039 Backpressure test: stimulus holds iStk_Ready=0 for 50 cycles at idx 3, then 1. Required response: idx3 and its data stay constant throughout, no index is skipped, and oBusy=0 after idx8.
REQ-040 Overlay test: stimulus is iX=266, iY=156. Required response: oDot=1. With iX=267, iY=156, oDot=0. With iX=504, iY=394, oDot=1.
REQ-041 Mid-frame reset test: stimulus pulses iRST_N low during ACCUM. Required response: oStk_Valid never rises, with or without subsequent vsync edges, until a new iCapture.
REQ-042 Ignored-capture test: stimulus applies iCapture during ACCUM and during OUTPUT. Required response: exactly one 9-result burst, then IDLE.
